// File: rtl/mvb_item_fifox_pkg.sv
// Shared helpers and types for the item-granular MVB FIFO.
package mvb_item_fifox_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c = c + int'(v[i]);
        return c;
    endfunction

    localparam int DEPTH_DEF = 16;
    localparam int PTR_W     = clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    // Wide enough for lane offsets and item counts of any practical MVB word.
    localparam int OFF_W = 8;
    typedef logic [OFF_W-1:0] lane_off_t;

endpackage

// File: rtl/mvb_item_fifox_if.sv
// MVB receive/transmit bus plus fill-level status of the item FIFO.
interface mvb_item_fifox_if #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int STAT_W = mvb_item_fifox_pkg::clog2(DEPTH) + 1;

    logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA;
    logic [ITEMS-1:0]            RX_VLD;
    logic                        RX_SRC_RDY;
    logic                        RX_DST_RDY;
    logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA;
    logic [ITEMS-1:0]            TX_VLD;
    logic                        TX_SRC_RDY;
    logic                        TX_DST_RDY;
    logic [STAT_W-1:0]           STATUS;
    logic                        AFULL;
    logic                        AEMPTY;

    modport slave (
        input  RX_DATA, RX_VLD, RX_SRC_RDY, TX_DST_RDY,
        output RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY, STATUS, AFULL, AEMPTY
    );

    modport master (
        output RX_DATA, RX_VLD, RX_SRC_RDY, TX_DST_RDY,
        input  RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY, STATUS, AFULL, AEMPTY
    );
endinterface

// File: rtl/mvb_lane_compact.sv
// Prefix-sum of the valid lanes: each valid lane learns its slot offset
// relative to the write pointer, and the total tells how far the pointer moves.
module mvb_lane_compact
    import mvb_item_fifox_pkg::*;
#(
    parameter int ITEMS = 4
) (
    input  logic [ITEMS-1:0]            vld,
    output lane_off_t [ITEMS-1:0]       off,
    output lane_off_t                   cnt
);

    always_comb begin
        lane_off_t acc;
        acc = '0;
        off = '0;
        for (int i = 0; i < ITEMS; i++) begin
            off[i] = acc;
            acc    = acc + lane_off_t'(vld[i]);
        end
        cnt = lane_off_t'(popcount(32'(vld)));
    end

endmodule

// File: rtl/mvb_item_fifox.sv
// Item-granular circular FIFO: stores only valid MVB lanes and emits them
// packed from lane 0, with fill-level status flags.
module mvb_item_fifox
    import mvb_item_fifox_pkg::*;
#(
    parameter int ITEMS         = 4,
    parameter int ITEM_WIDTH    = 8,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int AFULL_OFFSET  = 4,
    parameter int AEMPTY_OFFSET = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    mvb_item_fifox_if.slave  bus
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ITEM_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_num;

    lane_off_t [ITEMS-1:0] lane_off;
    lane_off_t             wr_num;

    logic rx_rdy;
    logic wr_fire;
    logic rd_fire;

    mvb_lane_compact #(
        .ITEMS (ITEMS)
    ) u_compact (
        .vld (bus.RX_VLD),
        .off (lane_off),
        .cnt (wr_num)
    );

    // Ready only when a whole word fits, regardless of how many lanes are valid.
    assign rx_rdy  = (CW'(DEPTH) - count_q) >= CW'(ITEMS);
    assign wr_fire = bus.RX_SRC_RDY && rx_rdy;
    assign rd_num  = (count_q > CW'(ITEMS)) ? CW'(ITEMS) : count_q;
    assign rd_fire = (count_q != '0) && bus.TX_DST_RDY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(wr_num);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(rd_num);
        end
        count_d = count_q + (wr_fire ? CW'(wr_num) : CW'(0))
                          - (rd_fire ? rd_num      : CW'(0));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the zeroed count makes old contents unreachable.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < ITEMS; i++) begin
            if (wr_fire && bus.RX_VLD[i]) begin
                mem[wr_ptr_q + PW'(lane_off[i])] <= bus.RX_DATA[i*ITEM_WIDTH +: ITEM_WIDTH];
            end
        end
    end

    for (genvar gi = 0; gi < ITEMS; gi++) begin : g_tx_lane
        assign bus.TX_DATA[gi*ITEM_WIDTH +: ITEM_WIDTH] = mem[rd_ptr_q + PW'(gi)];
        assign bus.TX_VLD[gi]                           = CW'(gi) < rd_num;
    end

    assign bus.TX_SRC_RDY = count_q != '0;
    assign bus.RX_DST_RDY = rx_rdy;
    assign bus.STATUS     = count_q;
    assign bus.AFULL      = (DEPTH - int'(count_q)) <= AFULL_OFFSET;
    assign bus.AEMPTY     = int'(count_q) <= AEMPTY_OFFSET;

endmodule

// File: doc/mvb_item_fifox.md
# mvb_item_fifox

Item-granular FIFO for the MVB bus, the next generation of the word-based FIFOX. It accepts up to ITEMS valid items per cycle in any lane pattern and stores each item individually in a circular buffer of DEPTH items, so sparse MVB words waste no space. It emits up to ITEMS items per cycle packed into the low lanes and exports fill-level status with almost-full and almost-empty flags. It sits between MVB producers and consumers wherever burst absorption and lane compaction are needed.

## Interface
- ITEMS, 4, MVB lanes per word, at least 1
- ITEM_WIDTH, 8, bits per item
- DEPTH, 16, buffer capacity in items; power of two, at least 2*ITEMS
- AFULL_OFFSET, 4, AFULL asserts when free items are at most this value
- AEMPTY_OFFSET, 4, AEMPTY asserts when stored items are at most this value
- CLK in 1: the single clock; all logic is on its rising edge
- RESET_N in 1: asynchronous, active-low reset
- RX_DATA in ITEMS*ITEM_WIDTH: input items; lane i occupies bits [i*ITEM_WIDTH +: ITEM_WIDTH]
- RX_VLD in ITEMS: per-lane item valid; any pattern is legal
- RX_SRC_RDY in 1: input word valid
- RX_DST_RDY out 1: block can accept a full word
- TX_DATA out ITEMS*ITEM_WIDTH: output items, packed from lane 0
- TX_VLD out ITEMS: per-lane valid, always a thermometer code from lane 0
- TX_SRC_RDY out 1: output word valid
- TX_DST_RDY in 1: consumer accepts the word
- STATUS out log2(DEPTH)+1: stored item count
- AFULL out 1: almost full
- AEMPTY out 1: almost empty

## Operation
- Write transfer: RX_SRC_RDY && RX_DST_RDY. Only lanes with RX_VLD=1 are stored, in ascending lane order, starting at wr_ptr. wr_ptr advances by popcount(RX_VLD), modulo DEPTH.
- A word with RX_SRC_RDY=1 and RX_VLD=0 transfers and stores nothing.
- RX_DST_RDY = (DEPTH - count) >= ITEMS. It is computed from the registered count only and never depends on TX.
- Read side: n = min(count, ITEMS). TX_VLD[k] = (k < n). TX_DATA lane k = mem[rd_ptr+k mod DEPTH]. TX_SRC_RDY = (count != 0).
- Read transfer: TX_SRC_RDY && TX_DST_RDY. All n valid items are consumed, and rd_ptr advances by n modulo DEPTH.
- Invalid TX lanes carry don't-care data. The bench must not check them.
- count_next = count + nwr - nrd. Simultaneous read and write is always legal. A write never overwrites unread data, which is guaranteed by the RX_DST_RDY rule.
- STATUS = count.
- AFULL = (DEPTH - count) <= AFULL_OFFSET.
- AEMPTY = count <= AEMPTY_OFFSET.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, so the full state is distinguishable from empty.
- Reset while RESET_N is low: pointers and count are 0 and all stored data is discarded. Memory contents are not reset.
- Reset output values: RX_DST_RDY=1, TX_SRC_RDY=0, TX_VLD=0, STATUS=0, AFULL=0, AEMPTY=1.

## Timing
- Latency: an item written on edge t appears on TX after edge t, so it is visible in cycle t+1. There is no combinational path from RX to TX.
- RX_DST_RDY, TX_SRC_RDY, TX_VLD, TX_DATA, STATUS, AFULL and AEMPTY are all functions of registered state only. No input-to-output combinational path exists.
- Throughput: ITEMS items per cycle on each side at the same time, provided count allows.
- Full boundary: once count > DEPTH-ITEMS, RX_DST_RDY drops in the next cycle even if fewer than ITEMS lanes would be valid. This is an accepted slack of up to ITEMS-1 items.
- Empty boundary: an item written into an empty FIFO is readable one cycle later.
- Wrap-around: a write or read crossing index DEPTH-1 continues at index 0 within the same cycle.
- Reset assertion mid-transfer aborts immediately. Outputs take their reset values asynchronously.
- Operation resumes on the first edge after RESET_N deasserts.

## Structure
- Shared package mvb_item_fifox_pkg holds:
  - function clog2
  - function popcount
  - localparams PTR_W = clog2(DEPTH) and CNT_W = PTR_W+1
  - typedef for the per-lane offset vector.
- Sub-module mvb_lane_compact, purely combinational:
  - computes, from RX_VLD, the prefix-sum offset of each valid lane and the popcount;
  - the top level uses these to address the memory write enables.
- Top level holds:
  - the memory register array;
  - wr_ptr, rd_ptr and count registers;
  - TX read muxing and status flags.

## Test plan
1. Reset then idle: RESET_N low for 3 cycles, then high → STATUS=0, AEMPTY=1, AFULL=0, TX_SRC_RDY=0, RX_DST_RDY=1.
2. Sparse compaction: write one word with RX_VLD=4'b1010 and data lanes {D,C,B,A}={0x44,0x33,0x22,0x11}, TX_DST_RDY=0 → next cycle TX_VLD=4'b0011, TX lane0=0x22, lane1=0x44, STATUS=2.
3. Fill: write 4 full words with TX_DST_RDY=0 → STATUS=16 and AFULL=1 after the 3rd word (12 stored), RX_DST_RDY=0 once STATUS exceeds 12, no data loss.
4. Wrap and simultaneous traffic: random RX_VLD patterns with TX_DST_RDY random at 50% for 10k cycles → output sequence equals input valid-item sequence, pointers wrap repeatedly, STATUS always matches the scoreboard.
5. Partial read: store 3 items 0x01..0x03, then TX_DST_RDY=1 for one cycle → TX_VLD=4'b0111 and the transfer takes all 3, STATUS=0, TX_SRC_RDY=0 next cycle.
6. Reset mid-stream: hold STATUS=9 and assert RESET_N low asynchronously between edges → TX_SRC_RDY=0 and STATUS=0 immediately. After release, the first new item written reads back correctly with no stale data.
